// File: rtl/disk_position_tracker.sv
// Tracks a 3-bit rotating position stream and derives direction, step/revolution
// pulses, a wrapping revolution count, and stall/skip fault indications.
module disk_position_tracker #(
    parameter int unsigned REV_W        = 8,
    parameter int unsigned STALL_CYCLES = 1000,
    parameter int unsigned STALL_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       pos,
    input  logic             pos_vld,
    output logic             locked,
    output logic             dir,
    output logic             step_pulse,
    output logic             rev_pulse,
    output logic [REV_W-1:0] rev_cnt,
    output logic             stalled,
    output logic             fault
);

    localparam int unsigned POS_W = 3;
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   last_pos_q, last_pos_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               locked_q, locked_d;
    logic               dir_q, dir_d;
    logic               step_pulse_q, step_pulse_d;
    logic               rev_pulse_q, rev_pulse_d;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
    logic               stalled_q, stalled_d;
    logic               fault_q, fault_d;

    logic [POS_W-1:0]   delta;
    logic [STALL_W-1:0] stall_inc;

    // Next-state and next-output logic; Start low overrides everything.
    always_comb begin
        state_d      = state_q;
        last_pos_d   = last_pos_q;
        stall_cnt_d  = stall_cnt_q;
        locked_d     = locked_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;
        rev_pulse_d  = 1'b0;
        rev_cnt_d    = rev_cnt_q;
        stalled_d    = stalled_q;
        fault_d      = fault_q;

        delta     = POS_W'(pos - last_pos_q);
        stall_inc = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                               : STALL_W'(stall_cnt_q + STALL_W'(1));

        if (!Start) begin
            state_d     = ST_IDLE;
            last_pos_d  = '0;
            stall_cnt_d = '0;
            locked_d    = 1'b0;
            dir_d       = 1'b0;
            rev_cnt_d   = '0;
            stalled_d   = 1'b0;
            fault_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pos_vld) begin
                        state_d     = ST_TRACK;
                        last_pos_d  = pos;
                        locked_d    = 1'b1;
                        stall_cnt_d = '0;
                    end
                end
                ST_TRACK: begin
                    // Default: no accepted step this cycle, so the stall timer advances.
                    stall_cnt_d = stall_inc;
                    stalled_d   = stalled_q | (stall_inc == STALL_MAX);
                    if (pos_vld) begin
                        case (delta)
                            3'd0: ;
                            3'd1: begin
                                dir_d        = 1'b1;
                                step_pulse_d = 1'b1;
                                last_pos_d   = pos;
                                stall_cnt_d  = '0;
                                stalled_d    = 1'b0;
                                if (pos == 3'd0) begin
                                    rev_cnt_d   = REV_W'(rev_cnt_q + REV_W'(1));
                                    rev_pulse_d = 1'b1;
                                end
                            end
                            3'd7: begin
                                dir_d        = 1'b0;
                                step_pulse_d = 1'b1;
                                last_pos_d   = pos;
                                stall_cnt_d  = '0;
                                stalled_d    = 1'b0;
                                if (pos == 3'd7) begin
                                    rev_cnt_d   = REV_W'(rev_cnt_q - REV_W'(1));
                                    rev_pulse_d = 1'b1;
                                end
                            end
                            default: begin
                                state_d     = ST_FAULT;
                                fault_d     = 1'b1;
                                locked_d    = 1'b0;
                                stall_cnt_d = stall_cnt_q;
                                stalled_d   = stalled_q;
                            end
                        endcase
                    end
                end
                ST_FAULT: begin
                    fault_d  = 1'b1;
                    locked_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_pos_q   <= '0;
            stall_cnt_q  <= '0;
            locked_q     <= 1'b0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            rev_pulse_q  <= 1'b0;
            rev_cnt_q    <= '0;
            stalled_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_pos_q   <= last_pos_d;
            stall_cnt_q  <= stall_cnt_d;
            locked_q     <= locked_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            rev_pulse_q  <= rev_pulse_d;
            rev_cnt_q    <= rev_cnt_d;
            stalled_q    <= stalled_d;
            fault_q      <= fault_d;
        end
    end

    assign locked     = locked_q;
    assign dir        = dir_q;
    assign step_pulse = step_pulse_q;
    assign rev_pulse  = rev_pulse_q;
    assign rev_cnt    = rev_cnt_q;
    assign stalled    = stalled_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_disk_position_tracker.sv
// Directed bench for disk_position_tracker with hand-computed expectations.
module tb_disk_position_tracker;

    localparam int unsigned REV_W = 8;

    logic             clk;
    logic             rst;
    logic             Start;
    logic [2:0]       pos;
    logic             pos_vld;
    logic             locked;
    logic             dir;
    logic             step_pulse;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_cnt;
    logic             stalled;
    logic             fault;

    int n_checks = 0;
    int n_errors = 0;

    disk_position_tracker #(
        .REV_W        (REV_W),
        .STALL_CYCLES (16),
        .STALL_W      (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .pos        (pos),
        .pos_vld    (pos_vld),
        .locked     (locked),
        .dir        (dir),
        .step_pulse (step_pulse),
        .rev_pulse  (rev_pulse),
        .rev_cnt    (rev_cnt),
        .stalled    (stalled),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of input, then land 1 time unit after the clock edge.
    task automatic drive(input logic [2:0] p, input logic v);
        pos     = p;
        pos_vld = v;
        @(posedge clk);
        #1;
        pos_vld = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic lk, input logic dr,
                              input logic sp, input logic rp, input logic [REV_W-1:0] rc,
                              input logic st, input logic ft);
        check({tag, ".locked"},     32'(locked),     32'(lk));
        check({tag, ".dir"},        32'(dir),        32'(dr));
        check({tag, ".step_pulse"}, 32'(step_pulse), 32'(sp));
        check({tag, ".rev_pulse"},  32'(rev_pulse),  32'(rp));
        check({tag, ".rev_cnt"},    32'(rev_cnt),    32'(rc));
        check({tag, ".stalled"},    32'(stalled),    32'(st));
        check({tag, ".fault"},      32'(fault),      32'(ft));
    endtask

    task automatic clear_block();
        Start = 1'b0;
        drive(3'd0, 1'b0);
        Start = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        Start   = 1'b0;
        pos     = 3'd0;
        pos_vld = 1'b0;
        #12;
        check_outs("reset", 0, 0, 0, 0, 8'h00, 0, 0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        Start = 1'b1;

        // Lock at 3
        drive(3'd3, 1'b1);
        check_outs("lock3", 1, 0, 0, 0, 8'h00, 0, 0);

        // Forward run through the 7->0 boundary
        clear_block();
        check_outs("clear1", 0, 0, 0, 0, 8'h00, 0, 0);
        drive(3'd5, 1'b1);
        check_outs("lock5", 1, 0, 0, 0, 8'h00, 0, 0);
        drive(3'd6, 1'b1);
        check_outs("fwd6", 1, 1, 1, 0, 8'h00, 0, 0);
        drive(3'd7, 1'b1);
        check_outs("fwd7", 1, 1, 1, 0, 8'h00, 0, 0);
        drive(3'd0, 1'b1);
        check_outs("fwd0", 1, 1, 1, 1, 8'h01, 0, 0);
        drive(3'd1, 1'b1);
        check_outs("fwd1", 1, 1, 1, 0, 8'h01, 0, 0);
        drive(3'd4, 1'b0);
        check_outs("novld", 1, 1, 0, 0, 8'h01, 0, 0);

        // Backward run through 0->7, then forward back across FF->00
        clear_block();
        check("clear2.rev_cnt", 32'(rev_cnt), 32'h0);
        drive(3'd1, 1'b1);
        check_outs("lock1", 1, 0, 0, 0, 8'h00, 0, 0);
        drive(3'd0, 1'b1);
        check_outs("bwd0", 1, 0, 1, 0, 8'h00, 0, 0);
        drive(3'd7, 1'b1);
        check_outs("bwd7", 1, 0, 1, 1, 8'hFF, 0, 0);
        drive(3'd6, 1'b1);
        check_outs("bwd6", 1, 0, 1, 0, 8'hFF, 0, 0);
        drive(3'd7, 1'b1);
        check_outs("ret7", 1, 1, 1, 0, 8'hFF, 0, 0);
        drive(3'd0, 1'b1);
        check_outs("ret0", 1, 1, 1, 1, 8'h00, 0, 0);

        // Skip fault and recovery
        clear_block();
        drive(3'd2, 1'b1);
        check_outs("lock2", 1, 0, 0, 0, 8'h00, 0, 0);
        drive(3'd5, 1'b1);
        check_outs("skip", 0, 0, 0, 0, 8'h00, 0, 1);
        drive(3'd6, 1'b1);
        check_outs("fault_ign1", 0, 0, 0, 0, 8'h00, 0, 1);
        drive(3'd3, 1'b1);
        check_outs("fault_ign2", 0, 0, 0, 0, 8'h00, 0, 1);
        clear_block();
        check_outs("fault_clr", 0, 0, 0, 0, 8'h00, 0, 0);
        drive(3'd4, 1'b1);
        check_outs("relock4", 1, 0, 0, 0, 8'h00, 0, 0);

        // Stall: held position, stalled exactly 16 cycles after lock
        clear_block();
        drive(3'd2, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            drive(3'd2, 1'b1);
        end
        check_outs("hold15", 1, 0, 0, 0, 8'h00, 0, 0);
        drive(3'd2, 1'b1);
        check_outs("hold16", 1, 0, 0, 0, 8'h00, 1, 0);
        drive(3'd2, 1'b0);
        drive(3'd2, 1'b0);
        check("stall_keep", 32'(stalled), 32'h1);
        drive(3'd3, 1'b1);
        check_outs("stall_step", 1, 1, 1, 0, 8'h00, 0, 0);

        // Start=0 wins over a simultaneous 7->0 sample
        clear_block();
        drive(3'd6, 1'b1);
        drive(3'd7, 1'b1);
        check_outs("pri7", 1, 1, 1, 0, 8'h00, 0, 0);
        Start = 1'b0;
        drive(3'd0, 1'b1);
        check_outs("pri_clr", 0, 0, 0, 0, 8'h00, 0, 0);
        Start = 1'b1;
        drive(3'd1, 1'b0);
        check_outs("pri_idle", 0, 0, 0, 0, 8'h00, 0, 0);

        // Asynchronous reset mid-TRACK, between clock edges
        drive(3'd6, 1'b1);
        drive(3'd7, 1'b1);
        drive(3'd0, 1'b1);
        check_outs("pre_rst", 1, 1, 1, 1, 8'h01, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, 0, 8'h00, 0, 0);
        #10;
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disk_position_tracker.md
Name: disk_position_tracker

Overview:
Reader side of the 3-bit spinning-disk position sequence. It samples a 3-bit position stream, such as the output of the disk counter or a rotary sensor, whenever a valid strobe is asserted. From that stream it derives rotation direction, per-step pulses, and a signed-wrap revolution count, and it flags stall and skip faults. It sits downstream of the position generator and feeds display/status logic.

Parameters:
REV_W, 8, width of revolution counter rev_cnt
STALL_CYCLES, 1000, clk cycles with no step before stalled asserts (must be >= 1, < 2**STALL_W)
STALL_W, 10, width of internal stall timer

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
Start  input  1  enable; low synchronously clears block to IDLE
pos  input  3  disk position sample
pos_vld  input  1  one-cycle strobe: pos valid this cycle
locked  output  1  tracker has reference position and no fault
dir  output  1  last step direction: 1 = forward (+1), 0 = backward (-1)
step_pulse  output  1  one-cycle pulse per accepted step
rev_pulse  output  1  one-cycle pulse on revolution boundary crossing (either direction)
rev_cnt  output  REV_W  revolution count, modulo 2**REV_W
stalled  output  1  level: no step for STALL_CYCLES cycles while TRACK
fault  output  1  level: illegal position jump detected

Behaviour:
- Reset (rst=0, async): state=IDLE, last_pos=0, stall timer=0; all outputs 0 (locked, dir, step_pulse, rev_pulse, rev_cnt, stalled, fault).
- All outputs registered; response to a pos_vld sample appears the cycle after the sampling edge (latency 1).
- Start=0 (synchronous, highest priority, overrides pos_vld): next state IDLE, all outputs and internal regs cleared as in reset.
- States: IDLE, TRACK, FAULT.
- IDLE, Start=1, pos_vld=1: last_pos<=pos, ->TRACK, locked<=1. No step_pulse, rev_cnt unchanged. Stall timer=0.
- TRACK, pos_vld=1: delta = (pos - last_pos) mod 8, computed in 3 bits.
  - delta=0: hold. No pulses; dir unchanged; stall timer keeps counting.
  - delta=1: forward step. dir<=1, step_pulse<=1, last_pos<=pos, stall timer<=0, stalled<=0. If last_pos=7 and pos=0: rev_cnt<=rev_cnt+1, wrapping all-ones->0, and rev_pulse<=1.
  - delta=7: backward step. dir<=0, step_pulse<=1, last_pos<=pos, stall timer<=0, stalled<=0. If last_pos=0 and pos=7: rev_cnt<=rev_cnt-1, wrapping 0->all-ones, and rev_pulse<=1.
  - delta 2..6: skip. ->FAULT, fault<=1, locked<=0. No step_pulse. rev_cnt, dir and last_pos unchanged.
- TRACK stall timer: increments every cycle without an accepted step. The timer saturates at STALL_CYCLES. stalled<=1 on the cycle the timer reaches STALL_CYCLES and holds until the next accepted step or until Start=0.
- FAULT: pos_vld ignored; fault=1, locked=0, stalled frozen, rev_cnt frozen. The only exits are Start=0 (to IDLE) or rst.
- step_pulse and rev_pulse are high for exactly one cycle per event. Back-to-back pos_vld on consecutive cycles must be handled, giving consecutive pulses.
- pos_vld=0: no sample; pos is ignored.

Test Plan:
- Reset/lock: rst low then high, Start=1, pos_vld with pos=3 -> next cycle locked=1, step_pulse=0, rev_cnt=0, dir=0.
- Forward wrap: after lock at 5, feed 6,7,0,1 with pos_vld -> four step_pulses, dir=1, rev_pulse only on the 7->0 sample, rev_cnt=1.
- Backward wrap: from lock at 1, feed 0,7,6 -> dir=0, rev_pulse on 0->7, rev_cnt=2**REV_W-1 (0xFF for REV_W=8).
- Skip fault: locked at 2, feed pos=5 -> fault=1, locked=0, no step_pulse; further samples ignored; Start=0 for one cycle then Start=1 + pos_vld with pos=4 -> locked=1, fault=0, rev_cnt=0.
- Stall: STALL_CYCLES=16, lock then hold pos constant with repeated pos_vld -> stalled=1 exactly 16 cycles after lock; next +1 step -> stalled=0 with step_pulse.
- Priority/async: Start=0 in the same cycle as a forward 7->0 sample -> no rev_pulse, state IDLE, rev_cnt=0; rst asserted mid-TRACK -> outputs 0 immediately, without waiting for a clk edge.
